rr_arbiter_lock: RTL and testbench
==================================

Name: rr_arbiter_lock

Overview:
- Parametrised round-robin arbiter for N requesters with a registered one-hot grant and grant locking: the owner keeps the grant until it drops its request.
- Optional hold-timeout forces rotation when other requesters are waiting.
- Exposes a live request count and the rotation pointer for 7-segment and LED debug decoders.
- Sits between request sources and a shared resource, one level up from the fixed 8-way arbiter.

Parameters:
- N, 8, number of requesters; legal range 2..32.
- MAX_HOLD, 4, maximum consecutive cycles one owner may hold the grant while others wait; 0 = no limit.
- IDX_W, $clog2(N), index width; derived, must not be overridden.
- CNT_W, $clog2(N+1), request-count width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_i  in  N  request vector; bit i high = requester i wants the resource.
- grant_o  out  N  registered one-hot grant; all-zero when idle.
- grant_idx_o  out  IDX_W  index of current owner; valid only when grant_valid_o=1.
- grant_valid_o  out  1  registered, high while any grant is held (equals |grant_o).
- last_idx_o  out  IDX_W  rotation pointer: index of most recent grant.
- req_cnt_o  out  CNT_W  combinational popcount of req_i.
- preempt_o  out  1  one-cycle registered pulse on a grant change caused by timeout.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; grant_o=0, grant_idx_o=0, grant_valid_o=0, preempt_o=0, hold_cnt=0.
  - last_idx_o=N-1, so requester 0 has top priority after reset.
- Arbitration function win(mask, ptr):
  - Search from index ptr+1 upward, wrapping N-1 -> 0.
  - Return the first i with mask[i]=1.
  - The search covers all N positions; ptr itself is checked last.
- FSM states: IDLE, OWN.
- IDLE:
  - |req_i=0: stay IDLE.
  - Otherwise next edge: grant_o=onehot(w), grant_idx_o=w, last_idx_o=w, where w=win(req_i, last_idx_o); hold_cnt=1; go OWN.
  - Latency from request assertion to grant = 1 cycle.
- OWN, owner k = grant_idx_o:
  - Release when req_i[k]=0 at a posedge:
    - Other requests pending: grant w=win(req_i, k) on that same edge, with no idle bubble; last_idx_o=w, hold_cnt=1, stay OWN.
    - No other requests: grant_o=0, grant_valid_o=0, go IDLE; last_idx_o stays k.
  - Timeout applies when MAX_HOLD>0, hold_cnt==MAX_HOLD, req_i[k]=1, and (req_i & ~onehot(k))!=0:
    - Grant w=win(req_i & ~onehot(k), k); last_idx_o=w, hold_cnt=1, preempt_o=1 for one cycle.
  - Timeout with no other requester: keep k and saturate hold_cnt at MAX_HOLD, with no preempt. Rotation is therefore enforced only under contention.
  - Otherwise: keep k; hold_cnt increments, saturating at MAX_HOLD.
- Width rules: hold_cnt width is $clog2(MAX_HOLD+1), minimum 1. Pointer wrap uses modulo N (not a power-of-two mask), so N=5 and similar values are legal.
- Grant invariants:
  - grant_o is always zero or one-hot.
  - grant_o is never given to a requester whose req_i was 0 at the deciding edge.
- Simultaneous events: release and timeout in the same cycle are treated as a release; preempt_o=0.
- Reset mid-operation: the state above is forced on the next edge regardless of req_i; any held grant is dropped.
- req_cnt_o is purely combinational and independent of state and reset.

Test Plan:
- Reset then req_i=8'h01 -> one cycle later grant_o=8'h01, grant_idx_o=0, last_idx_o=0, req_cnt_o=1.
- req_i=8'hFF with each owner releasing after 1 cycle -> grants in order 0,1,2,...,7,0 with no idle cycle between them; req_cnt_o=8 while all high.
- Owner 3 holds with req_i=8'h48 constant, MAX_HOLD=4 -> grant 3 for exactly 4 cycles, then grant_o=8'h40 with preempt_o=1 for one cycle; after 4 more cycles grant returns to 3.
- Sole requester 5 held for 20 cycles -> grant_o=8'h20 throughout, preempt_o never asserts.
- Owner 2 drops req while req_i[6] rises in the same cycle, timeout also due -> next edge grant 6, preempt_o=0; all requests drop -> grant_valid_o=0 next edge, last_idx_o=6.
- rst=0 while grant 4 is held -> next edge grant_o=0, last_idx_o=7; with N=5 and req_i=5'b10001 from last_idx=4 -> grant 0, then 4 after release, confirming the modulo-5 wrap.

Source files
------------

// File: rtl/rr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// rr_arbiter_lock
//   Round-robin arbiter for N requesters with grant locking: once a requester
//   owns the resource it keeps it until it drops its request. With MAX_HOLD>0
//   an owner that has held the grant for MAX_HOLD cycles is forced to hand over
//   when somebody else is waiting. Without contention the owner keeps it.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   req_i          request vector, bit i = requester i wants the resource
//   grant_o        registered one-hot grant, zero when idle
//   grant_idx_o    index of the current owner (meaningful when grant_valid_o)
//   grant_valid_o  registered, high while a grant is held
//   last_idx_o     rotation pointer: index of the most recent grant
//   req_cnt_o      combinational popcount of req_i
//   preempt_o      one-cycle pulse when a grant change was forced by timeout
// -----------------------------------------------------------------------------
module rr_arbiter_lock #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 4,
   parameter int IDX_W    = $clog2(N),
   parameter int CNT_W    = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_valid_o,
   output logic [IDX_W-1:0] last_idx_o,
   output logic [CNT_W-1:0] req_cnt_o,
   output logic             preempt_o
);

   // Hold counter is at least one bit wide even when MAX_HOLD=0.
   localparam int HC_RAW = $clog2(MAX_HOLD + 1);
   localparam int HC_W   = (HC_RAW < 1) ? 1 : HC_RAW;
   localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
   localparam logic [HC_W-1:0]  HOLD_ONE = HC_W'(1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

   typedef enum logic {IDLE, OWN} state_t;

   // Search upward from ptr+1 with a modulo-N wrap; ptr itself is visited
   // last, so a non-power-of-two N never probes a nonexistent requester.
   function automatic logic [IDX_W-1:0] win(input logic [N-1:0] mask,
                                            input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] sel;
      logic             found;
      int               pos;
      sel   = '0;
      found = 1'b0;
      for (int off = 1; off <= N; off++) begin
         pos = (int'(ptr) + off) % N;
         if (!found && mask[pos]) begin
            sel   = IDX_W'(pos);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   state_t           r_state;
   logic [N-1:0]     r_grant;
   logic [IDX_W-1:0] r_idx;
   logic             r_valid;
   logic [IDX_W-1:0] r_last;
   logic [HC_W-1:0]  r_hold;
   logic             r_preempt;

   state_t           w_state_next;
   logic [N-1:0]     w_grant_next;
   logic [IDX_W-1:0] w_idx_next;
   logic             w_valid_next;
   logic [IDX_W-1:0] w_last_next;
   logic [HC_W-1:0]  w_hold_next;
   logic             w_preempt_next;

   logic [N-1:0]     w_own_oh;
   logic [N-1:0]     w_others;
   logic             w_own_req;
   logic [IDX_W-1:0] w_win_req;
   logic [IDX_W-1:0] w_win_oth;
   logic [CNT_W-1:0] w_cnt;

   // Decode of the current owner; masks it out of the request vector.
   for (genvar gi = 0; gi < N; gi++) begin : g_own
      assign w_own_oh[gi] = (r_idx == IDX_W'(gi));
   end

   assign w_others  = req_i & ~w_own_oh;
   assign w_own_req = |(req_i & w_own_oh);
   assign w_win_req = win(req_i, r_last);
   // When the owner has released, w_others equals req_i, so the same search
   // serves both the release hand-over and the timeout hand-over.
   assign w_win_oth = win(w_others, r_idx);

   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < N; i++) begin
         w_cnt = w_cnt + CNT_W'(req_i[i]);
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_grant_next   = r_grant;
      w_idx_next     = r_idx;
      w_valid_next   = r_valid;
      w_last_next    = r_last;
      w_hold_next    = r_hold;
      w_preempt_next = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req_i) begin
               w_grant_next = onehot(w_win_req);
               w_idx_next   = w_win_req;
               w_last_next  = w_win_req;
               w_valid_next = 1'b1;
               w_hold_next  = HOLD_ONE;
               w_state_next = OWN;
            end
         end
         OWN: begin
            if (!w_own_req) begin
               // Release takes precedence over a timeout due in the same cycle.
               if (|w_others) begin
                  w_grant_next = onehot(w_win_oth);
                  w_idx_next   = w_win_oth;
                  w_last_next  = w_win_oth;
                  w_hold_next  = HOLD_ONE;
               end else begin
                  w_grant_next = '0;
                  w_valid_next = 1'b0;
                  w_state_next = IDLE;
               end
            end else if ((MAX_HOLD > 0) && (r_hold == HOLD_MAX) && (|w_others)) begin
               w_grant_next   = onehot(w_win_oth);
               w_idx_next     = w_win_oth;
               w_last_next    = w_win_oth;
               w_hold_next    = HOLD_ONE;
               w_preempt_next = 1'b1;
            end else if ((MAX_HOLD > 0) && (r_hold != HOLD_MAX)) begin
               w_hold_next = r_hold + HOLD_ONE;
            end
         end
         default: begin
            w_grant_next = '0;
            w_valid_next = 1'b0;
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_last    <= IDX_TOP;
         r_hold    <= '0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_grant   <= w_grant_next;
         r_idx     <= w_idx_next;
         r_valid   <= w_valid_next;
         r_last    <= w_last_next;
         r_hold    <= w_hold_next;
         r_preempt <= w_preempt_next;
      end
   end

   assign grant_o       = r_grant;
   assign grant_idx_o   = r_idx;
   assign grant_valid_o = r_valid;
   assign last_idx_o    = r_last;
   assign req_cnt_o     = w_cnt;
   assign preempt_o     = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_lock
//   Scoreboard bench for rr_arbiter_lock. Two instances: N=8/MAX_HOLD=4 (a)
//   and N=5/MAX_HOLD=4 (b) for the modulo wrap. Each row drives rst/req_i
//   just after a rising edge and queues the outputs expected during that
//   cycle (registered results of the previous row, popcount of this row).
//   A monitor per instance pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_lock;

   typedef struct {
      int         row;
      logic [7:0] req;
      logic [7:0] grant;
      logic [2:0] idx;
      logic       valid;
      logic [2:0] last;
      logic       pre;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a = 1'b0;
   logic [7:0] req_a = '0;
   logic [7:0] grant_a;
   logic [2:0] idx_a;
   logic       valid_a;
   logic [2:0] last_a;
   logic [3:0] cnt_a;
   logic       pre_a;

   logic       rst_b = 1'b0;
   logic [4:0] req_b = '0;
   logic [4:0] grant_b;
   logic [2:0] idx_b;
   logic       valid_b;
   logic [2:0] last_b;
   logic [2:0] cnt_b;
   logic       pre_b;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;
   int   row_a = 0;
   int   row_b = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rr_arbiter_lock #(.N(8), .MAX_HOLD(4)) u_dut_a (
      .clk(clk), .rst(rst_a), .req_i(req_a), .grant_o(grant_a),
      .grant_idx_o(idx_a), .grant_valid_o(valid_a), .last_idx_o(last_a),
      .req_cnt_o(cnt_a), .preempt_o(pre_a)
   );

   rr_arbiter_lock #(.N(5), .MAX_HOLD(4)) u_dut_b (
      .clk(clk), .rst(rst_b), .req_i(req_b), .grant_o(grant_b),
      .grant_idx_o(idx_b), .grant_valid_o(valid_b), .last_idx_o(last_b),
      .req_cnt_o(cnt_b), .preempt_o(pre_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step_a(input logic r, input logic [7:0] req, input logic [7:0] g,
                         input int idx, input logic v, input int last, input logic p);
      exp_t e;
      @(posedge clk);
      #1;
      rst_a   = r;
      req_a   = req;
      e.row   = row_a;
      e.req   = req;
      e.grant = g;
      e.idx   = 3'(idx);
      e.valid = v;
      e.last  = 3'(last);
      e.pre   = p;
      e.cnt   = 4'($countones(req));
      qa.push_back(e);
      row_a++;
   endtask

   task automatic step_b(input logic r, input logic [4:0] req, input logic [4:0] g,
                         input int idx, input logic v, input int last, input logic p);
      exp_t e;
      @(posedge clk);
      #1;
      rst_b   = r;
      req_b   = req;
      e.row   = row_b;
      e.req   = {3'b000, req};
      e.grant = {3'b000, g};
      e.idx   = 3'(idx);
      e.valid = v;
      e.last  = 3'(last);
      e.pre   = p;
      e.cnt   = 4'($countones(req));
      qb.push_back(e);
      row_b++;
   endtask

   always @(negedge clk) begin
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         $display("a row %0d req=%02h grant=%02h idx=%0d valid=%0d last=%0d pre=%0d cnt=%0d",
                  ea.row, ea.req, grant_a, idx_a, valid_a, last_a, pre_a, cnt_a);
         chk($sformatf("a%0d.grant", ea.row), 32'(grant_a), 32'(ea.grant));
         chk($sformatf("a%0d.valid", ea.row), 32'(valid_a), 32'(ea.valid));
         if (ea.valid)
            chk($sformatf("a%0d.idx", ea.row), 32'(idx_a), 32'(ea.idx));
         chk($sformatf("a%0d.last", ea.row), 32'(last_a), 32'(ea.last));
         chk($sformatf("a%0d.preempt", ea.row), 32'(pre_a), 32'(ea.pre));
         chk($sformatf("a%0d.req_cnt", ea.row), 32'(cnt_a), 32'(ea.cnt));
      end
   end

   always @(negedge clk) begin
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         $display("b row %0d req=%02h grant=%02h idx=%0d valid=%0d last=%0d pre=%0d cnt=%0d",
                  eb.row, eb.req, grant_b, idx_b, valid_b, last_b, pre_b, cnt_b);
         chk($sformatf("b%0d.grant", eb.row), 32'(grant_b), 32'(eb.grant));
         chk($sformatf("b%0d.valid", eb.row), 32'(valid_b), 32'(eb.valid));
         if (eb.valid)
            chk($sformatf("b%0d.idx", eb.row), 32'(idx_b), 32'(eb.idx));
         chk($sformatf("b%0d.last", eb.row), 32'(last_b), 32'(eb.last));
         chk($sformatf("b%0d.preempt", eb.row), 32'(pre_b), 32'(eb.pre));
         chk($sformatf("b%0d.req_cnt", eb.row), 32'(cnt_b), 32'(eb.cnt));
      end
   end

   initial begin
      // ---- instance a: N=8, MAX_HOLD=4 ----
      step_a(0, 8'h00, 8'h00, 0, 0, 7, 0);   // reset state visible
      step_a(1, 8'h01, 8'h00, 0, 0, 7, 0);
      step_a(1, 8'h00, 8'h01, 0, 1, 0, 0);   // 1-cycle latency grant 0
      step_a(1, 8'h00, 8'h00, 0, 0, 0, 0);   // released, idle
      step_a(0, 8'h00, 8'h00, 0, 0, 0, 0);   // reset again, pointer back to 7
      step_a(1, 8'hFF, 8'h00, 0, 0, 7, 0);
      // each owner releases after one cycle: 0..7 then 0, no bubble
      step_a(1, 8'hFE, 8'h01, 0, 1, 0, 0);
      step_a(1, 8'hFD, 8'h02, 1, 1, 1, 0);
      step_a(1, 8'hFB, 8'h04, 2, 1, 2, 0);
      step_a(1, 8'hF7, 8'h08, 3, 1, 3, 0);
      step_a(1, 8'hEF, 8'h10, 4, 1, 4, 0);
      step_a(1, 8'hDF, 8'h20, 5, 1, 5, 0);
      step_a(1, 8'hBF, 8'h40, 6, 1, 6, 0);
      step_a(1, 8'h7F, 8'h80, 7, 1, 7, 0);
      step_a(1, 8'h00, 8'h01, 0, 1, 0, 0);
      // owner 3 under contention with 6: timeout rotation both ways
      step_a(1, 8'h08, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step_a(1, 8'h48, 8'h08, 3, 1, 3, 0);
      step_a(1, 8'h48, 8'h40, 6, 1, 6, 1);
      for (int i = 0; i < 3; i++) step_a(1, 8'h48, 8'h40, 6, 1, 6, 0);
      step_a(1, 8'h20, 8'h08, 3, 1, 3, 1);
      // sole requester 5 for 20 cycles: never preempted
      for (int i = 0; i < 20; i++) step_a(1, 8'h20, 8'h20, 5, 1, 5, 0);
      step_a(1, 8'h04, 8'h20, 5, 1, 5, 0);
      // owner 2 reaches its hold limit, then releases while 6 arrives
      for (int i = 0; i < 4; i++) step_a(1, 8'h04, 8'h04, 2, 1, 2, 0);
      step_a(1, 8'h40, 8'h04, 2, 1, 2, 0);
      step_a(1, 8'h00, 8'h40, 6, 1, 6, 0);   // release wins, no preempt
      step_a(1, 8'h10, 8'h00, 0, 0, 6, 0);
      // reset while 4 is held
      step_a(0, 8'h10, 8'h10, 4, 1, 4, 0);
      step_a(1, 8'h10, 8'h00, 0, 0, 7, 0);
      step_a(1, 8'h00, 8'h10, 4, 1, 4, 0);
      step_a(1, 8'h00, 8'h00, 0, 0, 4, 0);

      // ---- instance b: N=5, modulo-5 wrap ----
      step_b(0, 5'b00000, 5'b00000, 0, 0, 4, 0);
      step_b(1, 5'b10001, 5'b00000, 0, 0, 4, 0);
      step_b(1, 5'b10000, 5'b00001, 0, 1, 0, 0);
      step_b(1, 5'b10001, 5'b10000, 4, 1, 4, 0);
      step_b(1, 5'b00000, 5'b10000, 4, 1, 4, 0);
      step_b(1, 5'b00001, 5'b00000, 0, 0, 4, 0);
      step_b(1, 5'b00000, 5'b00001, 0, 1, 0, 0);
      step_b(1, 5'b00000, 5'b00000, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("a.queue_drained", 32'(qa.size()), 32'd0);
      chk("b.queue_drained", 32'(qb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
